// File: rtl/if_id_stage.sv
// if_id_stage: fetch-to-decode register with a two-entry skid buffer and instruction field split.
module if_id_stage #(
    parameter int INSTR_W = 32,
    parameter int PC_W = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_pc_plus4,
    output logic [5:0]         opcode,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic [15:0]        imm16
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state, state_next;
    logic [INSTR_W-1:0] head_instr, skid_instr;
    logic [PC_W-1:0] head_pc, skid_pc;
    logic head_valid, accept, pop, load_head, load_skid, shift;
    assign head_valid = state != EMPTY;
    assign in_ready = state != FULL;
    assign out_valid = head_valid;
    assign accept = in_valid & in_ready;
    assign pop = head_valid & out_ready;
    always_comb begin
        state_next = state;
        load_head = 1'b0;
        load_skid = 1'b0;
        shift = 1'b0;
        case (state)
            EMPTY: begin
                load_head = accept;
                state_next = accept ? ONE : EMPTY;
            end
            ONE: begin
                load_head = pop & accept;
                load_skid = ~pop & accept;
                state_next = pop ? (accept ? ONE : EMPTY) : (accept ? FULL : ONE);
            end
            FULL: begin
                shift = pop;
                state_next = pop ? ONE : FULL;
            end
            default: state_next = EMPTY;
        endcase
        if (flush) state_next = EMPTY;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            head_instr <= NOP_INSTR;
            head_pc <= '0;
            skid_instr <= NOP_INSTR;
            skid_pc <= '0;
        end else begin
            state <= state_next;
            if (load_head) begin
                head_instr <= in_instr;
                head_pc <= in_pc;
            end else if (shift) begin
                head_instr <= skid_instr;
                head_pc <= skid_pc;
            end
            if (load_skid) begin
                skid_instr <= in_instr;
                skid_pc <= in_pc;
            end
        end
    end
    assign out_instr = head_valid ? head_instr : NOP_INSTR;
    assign out_pc = head_valid ? head_pc : '0;
    assign out_pc_plus4 = out_pc + PC_W'(4);
    assign opcode = out_instr[31:26];
    assign rs = out_instr[25:21];
    assign rt = out_instr[20:16];
    assign rd = out_instr[15:11];
    assign shamt = out_instr[10:6];
    assign funct = out_instr[5:0];
    assign imm16 = out_instr[15:0];
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: vector table, scoreboard-checked random stream and async reset checks for if_id_stage.
module tb_if_id_stage;
    logic clk, reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_instr, out_pc, out_pc_plus4;
    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd, shamt;
    logic [15:0] imm16;
    int n_vec = 0;
    int n_err = 0;

    if_id_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
        .out_pc_plus4(out_pc_plus4), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .funct(funct), .imm16(imm16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic v;
        logic [31:0] instr;
        logic [31:0] pc;
        logic ordy;
        logic fl;
        logic ev;
        logic eir;
        logic [31:0] einstr;
        logic [31:0] epc;
    } vec_t;
    vec_t tab[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic eir,
                           input logic [31:0] ei, input logic [31:0] ep);
        chk({tag, " out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, " in_ready"}, 32'(in_ready), 32'(eir));
        chk({tag, " out_instr"}, out_instr, ei);
        chk({tag, " out_pc"}, out_pc, ep);
        chk({tag, " out_pc_plus4"}, out_pc_plus4, ep + 32'd4);
        chk({tag, " fields"}, {opcode, rs, rt, rd, shamt, funct},
            {ei[31:26], ei[25:21], ei[20:16], ei[15:11], ei[10:6], ei[5:0]});
        chk({tag, " imm16"}, 32'(imm16), 32'(ei[15:0]));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_instr = 32'h0;
        in_pc = 32'h0;
        out_ready = 1'b0;
        flush = 1'b0;
    endtask

    logic [63:0] q[$];
    int sent, recv, cyc;
    logic [31:0] pc_next;
    logic acc, pp;
    logic [63:0] popped;

    initial begin
        tab[0]  = '{1'b1, 32'h2008_FFFF, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2008_FFFF, 32'h100};
        tab[1]  = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
        tab[2]  = '{1'b1, 32'h1111_1111, 32'h200, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 32'h200};
        tab[3]  = '{1'b1, 32'h2222_2222, 32'h204, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1111_1111, 32'h200};
        tab[4]  = '{1'b1, 32'h3333_3333, 32'h208, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1111_1111, 32'h200};
        tab[5]  = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2222_2222, 32'h204};
        tab[6]  = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
        tab[7]  = '{1'b1, 32'h4444_4444, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4444_4444, 32'hFFFF_FFFC};
        tab[8]  = '{1'b1, 32'h5555_5555, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4444_4444, 32'hFFFF_FFFC};
        tab[9]  = '{1'b1, 32'h6666_6666, 32'h8, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0};
        tab[10] = '{1'b1, 32'h7777_7777, 32'h10, 1'b1, 1'b0, 1'b1, 1'b1, 32'h7777_7777, 32'h10};
        tab[11] = '{1'b1, 32'h8888_8888, 32'h14, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8888_8888, 32'h14};
        tab[12] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};

        idle();
        reset = 1'b1;
        #2;
        chk_all("in_reset", 1'b0, 1'b1, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_all("after_reset", 1'b0, 1'b1, 32'h0, 32'h0);

        for (int i = 0; i < 13; i++) begin
            in_valid = tab[i].v;
            in_instr = tab[i].instr;
            in_pc = tab[i].pc;
            out_ready = tab[i].ordy;
            flush = tab[i].fl;
            @(posedge clk);
            #1;
            chk_all($sformatf("row%0d", i), tab[i].ev, tab[i].eir, tab[i].einstr, tab[i].epc);
            if (i == 0) begin
                chk("t1 opcode", 32'(opcode), 32'h08);
                chk("t1 rs", 32'(rs), 32'h0);
                chk("t1 rt", 32'(rt), 32'h8);
                chk("t1 imm16", 32'(imm16), 32'hFFFF);
                chk("t1 pc_plus4", out_pc_plus4, 32'h104);
            end
            if (i == 7) chk("wrap pc_plus4", out_pc_plus4, 32'h0);
        end

        idle();
        sent = 0;
        recv = 0;
        cyc = 0;
        pc_next = 32'h1000;
        while (!(sent == 100 && q.size() == 0) && cyc < 3000) begin
            in_valid = (sent < 100) && ($urandom_range(0, 9) < 7);
            in_instr = $urandom;
            in_pc = pc_next;
            out_ready = $urandom_range(0, 9) < 6;
            #3;
            chk("stream out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("stream in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0) begin
                chk("stream out_instr", out_instr, q[0][63:32]);
                chk("stream out_pc", out_pc, q[0][31:0]);
            end
            acc = in_valid && (q.size() < 2);
            pp = out_ready && (q.size() > 0);
            @(posedge clk);
            if (pp) begin
                popped = q.pop_front();
                recv++;
            end
            if (acc) begin
                q.push_back({in_instr, in_pc});
                sent++;
                pc_next = pc_next + 32'd4;
            end
            cyc++;
            #1;
        end
        chk("stream words received", 32'(recv), 32'd100);

        idle();
        in_valid = 1'b1;
        in_instr = 32'hAAAA_0001;
        in_pc = 32'h300;
        @(posedge clk);
        #1 in_instr = 32'hAAAA_0002;
        in_pc = 32'h304;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk_all("pre_async_full", 1'b1, 1'b0, 32'hAAAA_0001, 32'h300);
        #2 reset = 1'b1;
        #1;
        chk_all("async_reset", 1'b0, 1'b1, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        chk_all("held_reset", 1'b0, 1'b1, 32'h0, 32'h0);
        reset = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'hBBBB_0001;
        in_pc = 32'h400;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_all("first_after_reset", 1'b1, 1'b1, 32'hBBBB_0001, 32'h400);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
